// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Divider values assume a 50 MHz system clock.
package uart_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } uart_arb_state_t;

   localparam logic [15:0] COMP_9600   = 16'd5208;
   localparam logic [15:0] COMP_19200  = 16'd2604;
   localparam logic [15:0] COMP_38400  = 16'd1302;
   localparam logic [15:0] COMP_57600  = 16'd868;
   localparam logic [15:0] COMP_115200 = 16'd434;

   localparam logic [1:0] STOP_1   = 2'd0;
   localparam logic [1:0] STOP_1P5 = 2'd1;
   localparam logic [1:0] STOP_2   = 2'd2;

endpackage

// File: rtl/uart_rr_arb.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module uart_rr_arb #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned IW    = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IW-1:0]    ptr,
   output logic [N_REQ-1:0] gnt,
   output logic [IW-1:0]    gnt_idx,
   output logic             any_req
);

   logic              found;
   int unsigned       idx;
   logic [IW-1:0]     sel;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      idx     = 0;
      sel     = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         idx = (32'(ptr) + i) % N_REQ;
         sel = IW'(idx);
         if (!found && req[sel]) begin
            found        = 1'b1;
            gnt[sel]     = 1'b1;
            gnt_idx      = sel;
         end
      end
   end

   assign any_req = |req;

endmodule

// File: rtl/uart_tx_arb_sva.sv
// Protocol checks for uart_tx_arb, instantiated inside the top level.
module uart_tx_arb_sva #(
   parameter int unsigned N_REQ = 4
) (
   input logic             clk,
   input logic             reset,
   input logic [N_REQ-1:0] s_ready,
   input logic             busy,
   input logic             tx_req,
   input logic             frame_done
);

   a_ready_onehot : assert property (@(posedge clk) disable iff (reset) $onehot0(s_ready));
   a_ready_idle   : assert property (@(posedge clk) disable iff (reset) (|s_ready) |-> !busy);
   a_req_is_busy  : assert property (@(posedge clk) disable iff (reset) tx_req == busy);
   a_done_no_req  : assert property (@(posedge clk) disable iff (reset) frame_done |-> !tx_req);
   a_grant_to_req : assert property (@(posedge clk) disable iff (reset) (|s_ready) |=> tx_req);

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin sequencer sharing one uart_transmitter among N_REQ byte sources;
// line configuration is latched only while idle so it never changes mid-frame.
module uart_tx_arb
   import uart_pkg::*;
#(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned DW    = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      cfg_en,
   input  logic [15:0]               cfg_comp,
   input  logic [1:0]                cfg_stop_sel,
   input  logic [N_REQ-1:0]          s_valid,
   input  logic [N_REQ*DW-1:0]       s_data,
   output logic [N_REQ-1:0]          s_ready,
   output logic                      tx_req,
   output logic [DW-1:0]             tx_data,
   input  logic                      tx_req_ack,
   output logic [15:0]               comp,
   output logic [1:0]                stop_sel,
   output logic                      tr_en,
   output logic [$clog2(N_REQ)-1:0]  tx_src,
   output logic                      busy,
   output logic                      frame_done,
   output logic                      err_spur_ack
);

   localparam int unsigned IW = $clog2(N_REQ);

   uart_arb_state_t state_q, state_d;
   logic [IW-1:0]   ptr_q, ptr_d;
   logic            tx_req_q, tx_req_d;
   logic [DW-1:0]   tx_data_q, tx_data_d;
   logic [IW-1:0]   tx_src_q, tx_src_d;
   logic [15:0]     comp_q, comp_d;
   logic [1:0]      stop_sel_q, stop_sel_d;
   logic            tr_en_q, tr_en_d;
   logic            frame_done_q, frame_done_d;
   logic            err_q, err_d;

   logic [N_REQ-1:0] gnt;
   logic [IW-1:0]    gnt_idx;
   logic             any_req;
   logic             grant;
   logic [DW-1:0]    sel_data;

   uart_rr_arb #(
      .N_REQ (N_REQ),
      .IW    (IW)
   ) u_rr_arb (
      .req     (s_valid),
      .ptr     (ptr_q),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .any_req (any_req)
   );

   // Reset gates the strobe so no source is released into a cleared register.
   assign grant   = (state_q == IDLE) && !reset && cfg_en && any_req;
   assign s_ready = grant ? gnt : '0;

   always_comb begin
      sel_data = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (gnt[i]) begin
            sel_data = s_data[i*DW +: DW];
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      tx_req_d     = tx_req_q;
      tx_data_d    = tx_data_q;
      tx_src_d     = tx_src_q;
      comp_d       = comp_q;
      stop_sel_d   = stop_sel_q;
      tr_en_d      = tr_en_q;
      frame_done_d = 1'b0;
      err_d        = err_q;
      case (state_q)
         IDLE: begin
            comp_d     = cfg_comp;
            stop_sel_d = cfg_stop_sel;
            tr_en_d    = cfg_en;
            if (tx_req_ack) begin
               err_d = 1'b1;
            end
            if (grant) begin
               tx_data_d = sel_data;
               tx_src_d  = gnt_idx;
               tx_req_d  = 1'b1;
               state_d   = REQ;
               if (gnt_idx == IW'(N_REQ - 1)) begin
                  ptr_d = '0;
               end else begin
                  ptr_d = gnt_idx + 1'b1;
               end
            end
         end
         REQ: begin
            if (tx_req_ack) begin
               tx_req_d     = 1'b0;
               frame_done_d = 1'b1;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         ptr_q        <= '0;
         tx_req_q     <= 1'b0;
         tx_data_q    <= '0;
         tx_src_q     <= '0;
         comp_q       <= '0;
         stop_sel_q   <= '0;
         tr_en_q      <= 1'b0;
         frame_done_q <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         tx_req_q     <= tx_req_d;
         tx_data_q    <= tx_data_d;
         tx_src_q     <= tx_src_d;
         comp_q       <= comp_d;
         stop_sel_q   <= stop_sel_d;
         tr_en_q      <= tr_en_d;
         frame_done_q <= frame_done_d;
         err_q        <= err_d;
      end
   end

   assign tx_req       = tx_req_q;
   assign tx_data      = tx_data_q;
   assign tx_src       = tx_src_q;
   assign comp         = comp_q;
   assign stop_sel     = stop_sel_q;
   assign tr_en        = tr_en_q;
   assign busy         = (state_q == REQ);
   assign frame_done   = frame_done_q;
   assign err_spur_ack = err_q;

   uart_tx_arb_sva #(
      .N_REQ (N_REQ)
   ) u_sva (
      .clk        (clk),
      .reset      (reset),
      .s_ready    (s_ready),
      .busy       (busy),
      .tx_req     (tx_req),
      .frame_done (frame_done)
   );

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb with N_REQ=4: capture, fairness, config freeze,
// disable, spurious ack and reset mid-frame.
module tb_uart_tx_arb;

   logic        clk = 1'b0;
   logic        reset;
   logic        cfg_en;
   logic [15:0] cfg_comp;
   logic [1:0]  cfg_stop_sel;
   logic [3:0]  s_valid;
   logic [31:0] s_data;
   logic [3:0]  s_ready;
   logic        tx_req;
   logic [7:0]  tx_data;
   logic        tx_req_ack;
   logic [15:0] comp;
   logic [1:0]  stop_sel;
   logic        tr_en;
   logic [1:0]  tx_src;
   logic        busy;
   logic        frame_done;
   logic        err_spur_ack;

   int n_run  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   uart_tx_arb #(
      .N_REQ (4),
      .DW    (8)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .cfg_en       (cfg_en),
      .cfg_comp     (cfg_comp),
      .cfg_stop_sel (cfg_stop_sel),
      .s_valid      (s_valid),
      .s_data       (s_data),
      .s_ready      (s_ready),
      .tx_req       (tx_req),
      .tx_data      (tx_data),
      .tx_req_ack   (tx_req_ack),
      .comp         (comp),
      .stop_sel     (stop_sel),
      .tr_en        (tr_en),
      .tx_src       (tx_src),
      .busy         (busy),
      .frame_done   (frame_done),
      .err_spur_ack (err_spur_ack)
   );

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_run++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [1:0] exp_src;
      logic [7:0] exp_byte;

      reset        = 1'b1;
      cfg_en       = 1'b0;
      cfg_comp     = 16'd0;
      cfg_stop_sel = 2'd0;
      s_valid      = 4'b0000;
      s_data       = 32'h0;
      tx_req_ack   = 1'b0;
      tick();
      tick();

      // Reset state
      chk("rst_tx_req", tx_req, 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_tx_src", tx_src, 0);
      chk("rst_comp", comp, 0);
      chk("rst_stop_sel", stop_sel, 0);
      chk("rst_tr_en", tr_en, 0);
      chk("rst_busy", busy, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_err", err_spur_ack, 0);
      chk("rst_s_ready", s_ready, 0);
      reset = 1'b0;

      // Single source 2
      cfg_en   = 1'b1;
      cfg_comp = 16'd434;
      s_valid  = 4'b0100;
      s_data   = 32'h00A5_0000;
      #1;
      chk("single_s_ready", s_ready, 4'b0100);
      tick();
      chk("single_s_ready_off", s_ready, 0);
      s_valid = 4'b0000;
      chk("single_tx_req", tx_req, 1);
      chk("single_tx_data", tx_data, 8'hA5);
      chk("single_tx_src", tx_src, 2);
      chk("single_comp", comp, 434);
      chk("single_busy", busy, 1);
      tx_req_ack = 1'b1;
      tick();
      tx_req_ack = 1'b0;
      chk("single_done", frame_done, 1);
      chk("single_req_low", tx_req, 0);
      chk("single_idle", busy, 0);
      tick();
      chk("single_done_pulse", frame_done, 0);

      // Spurious ack in IDLE
      tx_req_ack = 1'b1;
      tick();
      tx_req_ack = 1'b0;
      chk("spur_err", err_spur_ack, 1);
      chk("spur_busy", busy, 0);
      chk("spur_no_done", frame_done, 0);
      tick();
      chk("spur_sticky", err_spur_ack, 1);

      // Reset mid-frame: pointer is 3 here so source 3 wins
      s_valid = 4'b1111;
      s_data  = 32'h4433_2211;
      #1;
      chk("rmf_s_ready", s_ready, 4'b1000);
      tick();
      chk("rmf_tx_src", tx_src, 3);
      chk("rmf_tx_req", tx_req, 1);
      reset = 1'b1;
      tick();
      chk("rmf_tx_req_0", tx_req, 0);
      chk("rmf_tx_data_0", tx_data, 0);
      chk("rmf_tx_src_0", tx_src, 0);
      chk("rmf_comp_0", comp, 0);
      chk("rmf_tr_en_0", tr_en, 0);
      chk("rmf_busy_0", busy, 0);
      chk("rmf_err_0", err_spur_ack, 0);
      chk("rmf_s_ready_0", s_ready, 0);
      reset = 1'b0;
      #1;

      // Fairness: eight frames with all sources valid, ack 3 cycles after tx_req
      for (int f = 0; f < 8; f++) begin
         exp_src  = 2'(f % 4);
         exp_byte = 8'((f % 4 + 1) * 17);
         chk($sformatf("rr%0d_s_ready", f), s_ready, 4'b0001 << exp_src);
         tick();
         chk($sformatf("rr%0d_tx_req", f), tx_req, 1);
         chk($sformatf("rr%0d_tx_src", f), tx_src, exp_src);
         chk($sformatf("rr%0d_tx_data", f), tx_data, exp_byte);
         tick();
         tick();
         tx_req_ack = 1'b1;
         tick();
         tx_req_ack = 1'b0;
         chk($sformatf("rr%0d_done", f), frame_done, 1);
         chk($sformatf("rr%0d_req_low", f), tx_req, 0);
         #1;
      end

      // Config change mid-frame: source 0 is granted in this IDLE cycle
      s_valid  = 4'b0001;
      cfg_comp = 16'd5208;
      cfg_stop_sel = 2'd0;
      tick();
      s_valid = 4'b0000;
      chk("cfg_comp_a", comp, 5208);
      chk("cfg_stop_a", stop_sel, 0);
      cfg_comp     = 16'd434;
      cfg_stop_sel = 2'd2;
      tick();
      chk("cfg_comp_frozen", comp, 5208);
      chk("cfg_stop_frozen", stop_sel, 0);
      tx_req_ack = 1'b1;
      tick();
      tx_req_ack = 1'b0;
      chk("cfg_done", frame_done, 1);
      chk("cfg_comp_at_done", comp, 5208);
      chk("cfg_stop_at_done", stop_sel, 0);
      tick();
      chk("cfg_comp_new", comp, 434);
      chk("cfg_stop_new", stop_sel, 2);

      // Disable mid-frame: pointer is 1
      s_valid = 4'b1111;
      #1;
      chk("dis_s_ready", s_ready, 4'b0010);
      tick();
      chk("dis_tx_src", tx_src, 1);
      cfg_en = 1'b0;
      tick();
      chk("dis_tr_en_req", tr_en, 1);
      tx_req_ack = 1'b1;
      tick();
      tx_req_ack = 1'b0;
      chk("dis_done", frame_done, 1);
      chk("dis_tr_en_done", tr_en, 1);
      chk("dis_no_ready", s_ready, 0);
      tick();
      chk("dis_tr_en_off", tr_en, 0);
      chk("dis_no_ready2", s_ready, 0);
      tick();
      chk("dis_no_req", tx_req, 0);
      chk("dis_idle", busy, 0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
